// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the multiply/divide unit: the 4-bit md_op operation
// codes (kept clear of the ALU code space by living in their own package) and
// the MDU state encoding.
// -----------------------------------------------------------------------------
package mdu_pkg;

    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MFHI  = 4'd7;
    localparam logic [3:0] MD_MFLO  = 4'd8;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

endpackage : mdu_pkg

// File: rtl/mdu.sv
// -----------------------------------------------------------------------------
// mdu
// Multi-cycle multiply/divide unit living in EX next to the ALU. Owns HI/LO.
// A mult/multu/div/divu is accepted only while idle; its result is computed at
// the accepting edge, held as a pending value, and committed to HI/LO after
// MULT_CYCLES / DIV_CYCLES busy cycles. mthi/mtlo write immediately when idle.
// Any md request while running is ignored.
//
// Configuration macro: MDU_DIVZERO_EN
//   defined   : div/divu by zero commits LO=32'hFFFF_FFFF, HI=A
//   undefined : div/divu by zero runs its full latency but leaves HI/LO as-is
//
// Ports
//   clk    in   1   rising-edge clock
//   reset  in   1   asynchronous, active-low reset
//   md_en  in   1   EX holds a valid md-class instruction
//   md_op  in   4   operation code (mdu_pkg::MD_*)
//   A      in   32  rs / dividend / multiplicand
//   B      in   32  rt / divisor / multiplier
//   busy   out  1   operation in flight, HI/LO not yet committed
//   C      out  32  HI when md_op==MD_MFHI, otherwise LO
// -----------------------------------------------------------------------------
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_en,
    input  logic [3:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] C
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic [63:0]       pend_q, pend_d;
    logic              commit_q, commit_d;

    logic              op_signed_s;
    logic [63:0]       a_ext_s;
    logic [63:0]       b_ext_s;
    logic [63:0]       prod_s;
    logic [31:0]       a_mag_s;
    logic [31:0]       b_mag_s;
    logic [31:0]       b_safe_s;
    logic [31:0]       quo_mag_s;
    logic [31:0]       rem_mag_s;
    logic [31:0]       quo_s;
    logic [31:0]       rem_s;

    // Arithmetic datapath: one shared 64-bit multiplier and one shared unsigned divider.
    always_comb begin
        op_signed_s = (md_op == MD_MULT) || (md_op == MD_DIV);

        // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then
        // correct for both signed and unsigned operands.
        a_ext_s = op_signed_s ? {{32{A[31]}}, A} : {32'd0, A};
        b_ext_s = op_signed_s ? {{32{B[31]}}, B} : {32'd0, B};
        prod_s  = a_ext_s * b_ext_s;

        // Signed division via magnitudes: |0x80000000| stays 0x80000000 as an
        // unsigned value, so 0x80000000 / -1 yields 0x80000000 rem 0 naturally.
        a_mag_s  = (op_signed_s && A[31]) ? (32'd0 - A) : A;
        b_mag_s  = (op_signed_s && B[31]) ? (32'd0 - B) : B;
        // Divide-by-zero is handled by the FSM; keep the divider well defined.
        b_safe_s = (b_mag_s == 32'd0) ? 32'd1 : b_mag_s;

        quo_mag_s = a_mag_s / b_safe_s;
        rem_mag_s = a_mag_s % b_safe_s;

        // Quotient truncates toward zero; remainder takes the dividend's sign.
        quo_s = (op_signed_s && (A[31] ^ B[31])) ? (32'd0 - quo_mag_s) : quo_mag_s;
        rem_s = (op_signed_s && A[31]) ? (32'd0 - rem_mag_s) : rem_mag_s;
    end

    // Next-state logic: operation acceptance, latency countdown and HI/LO commit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        pend_d   = pend_q;
        commit_d = commit_q;

        case (state_q)
            MD_IDLE: begin
                if (md_en) begin
                    case (md_op)
                        MD_MULT, MD_MULTU: begin
                            pend_d   = prod_s;
                            commit_d = 1'b1;
                            cnt_d    = MULT_LOAD;
                            state_d  = MD_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            cnt_d   = DIV_LOAD;
                            state_d = MD_RUN;
                            if (B == 32'd0) begin
`ifdef MDU_DIVZERO_EN
                                pend_d   = {A, 32'hFFFF_FFFF};
                                commit_d = 1'b1;
`else
                                pend_d   = pend_q;
                                commit_d = 1'b0;
`endif
                            end else begin
                                pend_d   = {rem_s, quo_s};
                                commit_d = 1'b1;
                            end
                        end
                        MD_MTHI: begin
                            hi_d = A;
                        end
                        MD_MTLO: begin
                            lo_d = A;
                        end
                        default: begin
                            state_d = MD_IDLE;
                        end
                    endcase
                end else begin
                    state_d = MD_IDLE;
                end
            end
            MD_RUN: begin
                // Requests arriving while running are deliberately not looked at.
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = MD_IDLE;
                    if (commit_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end else begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase
    end

    // State, counter, pending result and HI/LO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= MD_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            pend_q   <= 64'd0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            pend_q   <= pend_d;
            commit_q <= commit_d;
        end
    end

    assign busy = (state_q == MD_RUN);
    assign C    = (md_op == MD_MFHI) ? hi_q : lo_q;

endmodule : mdu

// File: tb/tb_mdu.sv
module tb_mdu;
    import mdu_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        md_en;
    logic [3:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] C;

    int total;
    int bad;

    // Model state: architectural HI/LO as the program would see them.
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    // Scoreboard queues: expected read data, expected busy lengths.
    logic [31:0] rd_q[$];
    string       rd_name_q[$];
    int          lat_q[$];

    mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .md_en (md_en),
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .C     (C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {HI,LO} result of a mult/div given operands and prior HI/LO.
    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] prior);
        int              sa, sb;
        longint          pa, pb;
        longint unsigned ua, ub;
        logic [63:0]     r;
        r = prior;
        sa = a;
        sb = b;
        case (op)
            MD_MULT: begin
                pa = sa; pb = sb;
                r = pa * pb;
            end
            MD_MULTU: begin
                ua = {32'd0, a}; ub = {32'd0, b};
                r = ua * ub;
            end
            MD_DIV, MD_DIVU: begin
                if (b == 32'd0) begin
`ifdef MDU_DIVZERO_EN
                    r = {a, 32'hFFFF_FFFF};
`else
                    r = prior;
`endif
                end else if (op == MD_DIVU) begin
                    r = {a % b, a / b};
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r = {32'd0, 32'h8000_0000};
                end else begin
                    r = {32'(sa % sb), 32'(sa / sb)};
                end
            end
            default: r = prior;
        endcase
        return r;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endfunction

    // Monitor: compares read data and busy-pulse lengths as the DUT presents them.
    initial begin
        int cnt;
        logic [31:0] e;
        string n;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                cnt = 0;
                lat_q.delete();
            end else begin
                if (busy) begin
                    cnt++;
                end else if (cnt > 0) begin
                    if (lat_q.size() == 0) begin
                        check("unexpected_busy", 32'(cnt), 32'd0);
                    end else begin
                        check("busy_len", 32'(cnt), 32'(lat_q.pop_front()));
                    end
                    cnt = 0;
                end
                if (md_en && !busy && (md_op == MD_MFHI || md_op == MD_MFLO)) begin
                    if (rd_q.size() == 0) begin
                        check("unexpected_read", C, 32'hDEAD_BEEF);
                    end else begin
                        e = rd_q.pop_front();
                        n = rd_name_q.pop_front();
                        check(n, C, e);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit accept);
        @(posedge clk); #1;
        md_en = 1'b1; md_op = op; A = a; B = b;
        if (accept) begin
            case (op)
                MD_MULT, MD_MULTU: begin
                    lat_q.push_back(MULT_N);
                    {hi_m, lo_m} = ref_result(op, a, b, {hi_m, lo_m});
                end
                MD_DIV, MD_DIVU: begin
                    lat_q.push_back(DIV_N);
                    {hi_m, lo_m} = ref_result(op, a, b, {hi_m, lo_m});
                end
                MD_MTHI: hi_m = a;
                MD_MTLO: lo_m = a;
                default: ;
            endcase
        end
        @(posedge clk); #1;
        md_en = 1'b0; md_op = MD_MFLO;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (busy) begin
            bad++;
            $display("FAIL wait_idle: busy still %0b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic read(input bit hi, input bit now, input string name);
        if (!now) begin
            @(posedge clk); #1;
        end
        md_en = 1'b1;
        md_op = hi ? MD_MFHI : MD_MFLO;
        rd_q.push_back(hi ? hi_m : lo_m);
        rd_name_q.push_back(name);
        @(posedge clk); #1;
        md_en = 1'b0;
        md_op = MD_MFLO;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string name);
        issue(op, a, b, 1'b1);
        wait_idle();
        read(1'b1, 1'b1, {name, "_hi"});
        read(1'b0, 1'b0, {name, "_lo"});
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = 32'h7FFF_FFFF;
            4: v = 32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        logic [3:0]  ops [0:7];
        logic [3:0]  op;
        logic [31:0] a, b;
        total = 0; bad = 0;
        hi_m = 32'd0; lo_m = 32'd0;
        ops[0] = MD_MULT; ops[1] = MD_MULTU; ops[2] = MD_DIV;  ops[3] = MD_DIVU;
        ops[4] = MD_MTHI; ops[5] = MD_MTLO;  ops[6] = 4'd0;    ops[7] = 4'd15;
        reset = 1'b0; md_en = 1'b0; md_op = MD_MFLO; A = 32'd0; B = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        read(1'b1, 1'b0, "reset_hi");
        read(1'b0, 1'b0, "reset_lo");

        // Directed cases.
        run_op(MD_MULT,  32'hFFFF_FFFE, 32'd3, "mult");
        run_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, "multu");
        run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, "div");
        run_op(MD_DIVU,  32'd7,         32'd2, "divu");
        run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");

        // Requests during busy are ignored and do not restart the count.
        issue(MD_MTHI, 32'h0000_1234, 32'd0, 1'b1);
        read(1'b1, 1'b0, "mthi");
        issue(MD_MULTU, 32'd6, 32'd7, 1'b1);
        issue(MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        issue(MD_MTHI, 32'h0000_9999, 32'd0, 1'b0);
        wait_idle();
        read(1'b1, 1'b1, "ignored_hi");
        read(1'b0, 1'b0, "ignored_lo");

        // Reset in the middle of a divide.
        issue(MD_DIV, 32'd100, 32'd7, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        hi_m = 32'd0; lo_m = 32'd0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_lo", C, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        issue(MD_MTLO, 32'd5, 32'd0, 1'b1);
        read(1'b0, 1'b0, "mtlo_after_reset");
        read(1'b1, 1'b0, "hi_after_reset");

        // Divide by zero, with known prior values.
        issue(MD_MTHI, 32'hAAAA_0001, 32'd0, 1'b1);
        run_op(MD_DIVU, 32'd9, 32'd0, "divu_zero");
        run_op(MD_DIV, 32'hFFFF_FFF0, 32'd0, "div_zero");

        // Randomized sequence.
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 7)];
            a = pick_operand();
            b = pick_operand();
            if (op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU) begin
                run_op(op, a, b, $sformatf("rnd%0d_op%0d", i, op));
            end else begin
                issue(op, a, b, 1'b1);
                read(1'b1, 1'b0, $sformatf("rnd%0d_hi", i));
                read(1'b0, 1'b0, $sformatf("rnd%0d_lo", i));
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("rd_queue_empty", 32'(rd_q.size()), 32'd0);
        check("lat_queue_empty", 32'(lat_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mdu
